// File: rtl/spi_pkg.sv
// Shared definitions for the SPI frame link: frame width, FSM states,
// receiver-compatibility limits and a small elaboration helper.
package spi_pkg;

  // Command frame width on the controller-to-FPGA link.
  localparam int SPI_FRAME_W = 33;

  // Bit counter width; large enough to hold FRAME_W without wrapping.
  localparam int BIT_CNT_W = 6;

  // Timing the oversampled frame receiver needs to lock on:
  // spi_clk half-period (clk cycles) and total CS-low time (clk cycles).
  localparam int RX_MIN_HALF_PER = 103;
  localparam int RX_MIN_CS_LOW   = 6858;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    HOLD,
    GAP
  } spi_state_e;

  // Larger of two elaboration-time integers (used for timer sizing).
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_frame_tx_timer.sv
// Phase timer for spi_frame_tx: counts clk cycles spent in the current
// phase and flags the last cycle of that phase.
module spi_phase_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic [W-1:0] limit,
  output logic         expired
);

  logic [W-1:0] cnt;

  // Last cycle of a phase of 'limit' cycles.
  assign expired = (cnt == limit - 1'b1);

  // Up-counter, restarted from 0 whenever the phase ends or the FSM idles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              cnt <= '0;
    else if (clr || expired) cnt <= '0;
    else                     cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/spi_frame_tx.sv
// SPI master (CPOL=0, MSB first) for 33-bit command frames. One word per
// valid/ready handshake; CS low for 67 half-periods, then a CS-high gap.
module spi_frame_tx
  import spi_pkg::*;
#(
  parameter int HALF_PER = 125,
  parameter int CS_IDLE  = 256,
  parameter int FRAME_W  = SPI_FRAME_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [FRAME_W-1:0] tx_data,
  input  logic               tx_valid,
  output logic               tx_ready,
  output logic               spi_clk,
  output logic               spi_cs,
  output logic               spi_out,
  output logic               busy,
  output logic               done
);

  localparam int TW = $clog2(max2(HALF_PER, CS_IDLE) + 1);
  localparam logic [TW-1:0]        HP_LIM   = TW'(HALF_PER);
  localparam logic [TW-1:0]        GAP_LIM  = TW'(CS_IDLE);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_W);

  // Reject parameter sets the timing scheme cannot honour.
  if (HALF_PER < 2) begin : g_bad_half_per
    $error("spi_frame_tx: HALF_PER must be >= 2");
  end
  if (CS_IDLE < 1) begin : g_bad_cs_idle
    $error("spi_frame_tx: CS_IDLE must be >= 1");
  end
  if (FRAME_W < 2 || FRAME_W >= (1 << BIT_CNT_W)) begin : g_bad_frame_w
    $error("spi_frame_tx: FRAME_W out of range for the bit counter");
  end

  spi_state_e             state;
  logic [FRAME_W-1:0]     shift;
  logic [BIT_CNT_W-1:0]   bit_cnt;
  logic                   ph_end;
  logic                   tmr_clr;
  logic [TW-1:0]          tmr_limit;

  // Only the gap phase uses the CS_IDLE length; every other phase is a
  // spi_clk half-period. The timer sits at 0 while idle.
  assign tmr_clr   = (state == IDLE);
  assign tmr_limit = (state == GAP) ? GAP_LIM : HP_LIM;
  assign tx_ready  = (state == IDLE);

  spi_phase_timer #(.W(TW)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (tmr_clr),
    .limit   (tmr_limit),
    .expired (ph_end)
  );

  // Frame FSM with registered pin outputs; data moves only on the
  // HIGH->LOW transition so it is stable a full half-period around each
  // rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      shift   <= '0;
      bit_cnt <= '0;
      spi_cs  <= 1'b1;
      spi_clk <= 1'b0;
      spi_out <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_valid) begin
            state   <= SETUP;
            shift   <= tx_data;
            bit_cnt <= '0;
            spi_cs  <= 1'b0;
            spi_clk <= 1'b0;
            spi_out <= tx_data[FRAME_W-1];
            busy    <= 1'b1;
          end
        end
        SETUP: begin
          spi_out <= shift[FRAME_W-1];
          if (ph_end) begin
            state   <= HIGH;
            spi_clk <= 1'b1;
          end
        end
        HIGH: begin
          if (ph_end) begin
            bit_cnt <= bit_cnt + 1'b1;
            spi_clk <= 1'b0;
            if (bit_cnt + 1'b1 == LAST_BIT) begin
              state <= HOLD;
            end else begin
              state   <= LOW;
              shift   <= {shift[FRAME_W-2:0], 1'b0};
              spi_out <= shift[FRAME_W-2];
            end
          end
        end
        LOW: begin
          if (ph_end) begin
            state   <= HIGH;
            spi_clk <= 1'b1;
          end
        end
        HOLD: begin
          if (ph_end) begin
            state   <= GAP;
            spi_cs  <= 1'b1;
            spi_out <= 1'b0;
            done    <= 1'b1;
          end
        end
        GAP: begin
          if (ph_end) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_tx.sv
// Bench for spi_frame_tx: a pin-level monitor rebuilds each frame from the
// SPI lines and the main sequence compares it with the timing/word rules.
module tb_spi_frame_tx;
  import spi_pkg::*;

  localparam int W   = SPI_FRAME_W;
  localparam int HP  = 4;
  localparam int GI  = 8;
  localparam int HPD = 125;
  localparam int GID = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---- DUT A: short timing ----
  logic [W-1:0] tx_data = '0;
  logic         tx_valid = 1'b0;
  logic tx_ready, spi_clk, spi_cs, spi_out, busy, done;

  spi_frame_tx #(.HALF_PER(HP), .CS_IDLE(GI)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .spi_clk(spi_clk), .spi_cs(spi_cs),
    .spi_out(spi_out), .busy(busy), .done(done)
  );

  // ---- DUT B: default timing, looped back into a receiver model ----
  logic [W-1:0] b_data = '0;
  logic         b_valid = 1'b0;
  logic b_ready, b_sclk, b_cs, b_sdo, b_busy, b_done;

  spi_frame_tx #(.HALF_PER(HPD), .CS_IDLE(GID)) dut_def (
    .clk(clk), .rst_n(rst_n), .tx_data(b_data), .tx_valid(b_valid),
    .tx_ready(b_ready), .spi_clk(b_sclk), .spi_cs(b_cs),
    .spi_out(b_sdo), .busy(b_busy), .done(b_done)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // ---- frame monitor on DUT A (samples at negedge) ----
  typedef struct {
    logic [W-1:0] word;
    int           nbits;
    int           cs_low;
    int           cs_fall;
    int           first_rise;
    int           last_rise;
    int           done_cyc;
    logic         done_ok;
  } frame_t;

  frame_t frq[$];
  frame_t cur;
  logic   in_fr = 1'b0;
  logic   p_sclk = 1'b0, p_cs = 1'b1, p_out = 1'b0;
  int     out_age = 1000, rise_age = 1000;
  int     viol_su = 0, viol_ho = 0, viol_cs = 0, stray_done = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_fr    = 1'b0;
      out_age  = 1000;
      rise_age = 1000;
      if (done) stray_done++;
    end else begin
      logic chg;
      chg      = (spi_out !== p_out);
      out_age  = chg ? 0 : out_age + 1;
      rise_age = rise_age + 1;
      if (chg && rise_age < HP) viol_ho++;
      if (spi_cs !== p_cs && spi_clk) viol_cs++;
      if (p_cs && !spi_cs) begin
        in_fr = 1'b1;
        cur = '{default: 0};
        cur.cs_fall = cyc;
      end
      if (!spi_cs && in_fr) cur.cs_low++;
      if (spi_clk && !p_sclk) begin
        if (out_age < HP) viol_su++;
        rise_age = 0;
        if (in_fr) begin
          cur.word = {cur.word[W-2:0], spi_out};
          cur.nbits++;
          if (cur.nbits == 1) cur.first_rise = cyc;
          cur.last_rise = cyc;
        end
      end
      if (!p_cs && spi_cs && in_fr) begin
        cur.done_cyc = cyc;
        cur.done_ok  = done;
        frq.push_back(cur);
        in_fr = 1'b0;
      end else if (done) begin
        stray_done++;
      end
    end
    p_sclk = spi_clk;
    p_cs   = spi_cs;
    p_out  = spi_out;
  end

  // ---- receiver model for DUT B ----
  logic [W-1:0] rx_sh = '0, rx_word = '0;
  int           rx_n = 0, rx_low = 0, rx_cnt = 0;
  logic         rx_flag = 1'b0;
  logic         bp_cs = 1'b1, bp_sclk = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bp_cs && !b_cs) begin rx_sh = '0; rx_n = 0; rx_low = 0; end
      if (!b_cs) rx_low++;
      if (!b_cs && b_sclk && !bp_sclk) begin rx_sh = {rx_sh[W-2:0], b_sdo}; rx_n++; end
      if (!bp_cs && b_cs) begin
        rx_word = rx_sh;
        rx_flag = (rx_n == W) && (rx_low > RX_MIN_CS_LOW) && b_done;
        rx_cnt++;
      end
    end
    bp_cs   = b_cs;
    bp_sclk = b_sclk;
  end

  // ---- helpers ----
  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (tx_ready) begin ok = 1'b1; return; end
      @(negedge clk);
    end
  endtask

  // Handshake one word; tx_data is scrambled right after acceptance.
  task automatic send(input logic [W-1:0] w, output int d);
    bit ok;
    wait_ready(ok);
    if (!ok) chk("ready_timeout", 0, 1);
    tx_data  = w;
    tx_valid = 1'b1;
    d = cyc;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = {$urandom_range(1, 0) == 1, $urandom()};
  endtask

  task automatic wait_frame(output frame_t f, output bit ok);
    f  = '{default: 0};
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (frq.size() > 0) begin f = frq.pop_front(); ok = 1'b1; return; end
      @(negedge clk);
    end
  endtask

  task automatic verify(input string nm, input logic [W-1:0] w, input int d,
                        input int ebits, input int ecs, output frame_t f);
    bit ok;
    wait_frame(f, ok);
    if (!ok) begin chk({nm, "_timeout"}, 0, 1); return; end
    chk({nm, "_word"},   f.word, w);
    chk({nm, "_bits"},   f.nbits, ebits);
    chk({nm, "_cslow"},  f.cs_low, ecs);
    chk({nm, "_csfall"}, f.cs_fall - d, 1);
    chk({nm, "_rise1"},  f.first_rise - f.cs_fall, HP);
    chk({nm, "_riseN"},  f.last_rise - f.cs_fall, (2 * W - 1) * HP);
    chk({nm, "_done"},   f.done_ok, 1);
  endtask

  typedef struct {
    logic [W-1:0] data;
    logic [W-1:0] exp_word;
    int           exp_bits;
    int           exp_cs_low;
  } vec_t;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t   tbl[$];
    frame_t f, f1;
    int     d, d2, nf;
    bit     ok;
    logic [W-1:0] w;

    tbl.push_back('{33'h1_5555_AAAA, 33'h1_5555_AAAA, W, 67 * HP});
    tbl.push_back('{33'h0_0000_0000, 33'h0_0000_0000, W, 67 * HP});
    tbl.push_back('{33'h1_FFFF_FFFF, 33'h1_FFFF_FFFF, W, 67 * HP});
    tbl.push_back('{33'h1_0000_0000, 33'h1_0000_0000, W, 67 * HP});
    tbl.push_back('{33'h0_8000_0001, 33'h0_8000_0001, W, 67 * HP});

    // Reset held with a pending word: no handshake, reset pin values.
    rst_n    = 1'b0;
    tx_valid = 1'b1;
    tx_data  = 33'h1_2345_6789;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_pins", {spi_cs, spi_clk, spi_out, busy, done, tx_ready}, 6'b100001);
    end
    tx_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", {busy, tx_ready}, 2'b01);

    // Table-driven frames.
    foreach (tbl[i]) begin
      send(tbl[i].data, d);
      verify($sformatf("tbl%0d", i), tbl[i].exp_word, d, tbl[i].exp_bits, tbl[i].exp_cs_low, f);
      ok = 1'b0;
      for (int k = 0; k < 100; k++) begin
        if (tx_ready) begin ok = 1'b1; break; end
        @(negedge clk);
      end
      chk($sformatf("tbl%0d_ready_gap", i), ok ? cyc - f.done_cyc : -1, GI);
    end

    // tx_valid held high across two words; data changes mid-frame.
    wait_ready(ok);
    tx_data  = 33'h0_0000_0001;
    tx_valid = 1'b1;
    d = cyc;
    @(negedge clk);
    chk("hv_busy", busy, 1);
    tx_data = 33'h1_FFFF_FFFF;
    verify("hv1", 33'h0_0000_0001, d, W, 67 * HP, f1);
    d2 = -1;
    for (int k = 0; k < 100; k++) begin
      if (tx_ready) begin d2 = cyc; break; end
      @(negedge clk);
    end
    @(negedge clk);
    tx_valid = 1'b0;
    chk("hv_second_accept", d2 - f1.done_cyc, GI);
    verify("hv2", 33'h1_FFFF_FFFF, d2, W, 67 * HP, f);

    // Reset during HIGH of bit 10, then a clean frame.
    send({$urandom_range(1, 0) == 1, $urandom()}, d);
    for (int k = 0; k < 2000; k++) begin
      if (in_fr && cur.nbits == 10 && spi_clk) break;
      @(negedge clk);
    end
    chk("rst_mid_state", {in_fr, spi_clk}, 2'b11);
    nf = frq.size();
    #2 rst_n = 1'b0;
    #1 chk("rst_mid_pins", {spi_cs, spi_clk, spi_out, busy, done, tx_ready}, 6'b100001);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_mid_no_frame", frq.size(), nf);
    send(33'h0_1234_5678, d);
    verify("post_rst", 33'h0_1234_5678, d, W, 67 * HP, f);

    // Random words.
    for (int i = 0; i < 6; i++) begin
      w = {$urandom_range(1, 0) == 1, $urandom()};
      send(w, d);
      verify($sformatf("rnd%0d", i), w, d, W, 67 * HP, f);
    end

    // Pin-level rules accumulated over every frame above.
    chk("setup_viol", viol_su, 0);
    chk("hold_viol", viol_ho, 0);
    chk("cs_toggle_clk_high", viol_cs, 0);
    chk("stray_done", stray_done, 0);

    // Loopback at default timing.
    for (int j = 0; j < 2; j++) begin
      int c0;
      w  = (j == 0) ? 33'h0_DEAD_BEEF : 33'h1_0F0F_F0F0;
      c0 = rx_cnt;
      ok = 1'b0;
      for (int k = 0; k < 1000; k++) begin
        if (b_ready) begin ok = 1'b1; break; end
        @(negedge clk);
      end
      b_data  = w;
      b_valid = 1'b1;
      @(negedge clk);
      b_valid = 1'b0;
      b_data  = ~w;
      for (int k = 0; k < 20000; k++) begin
        if (rx_cnt != c0) break;
        @(negedge clk);
      end
      chk($sformatf("lb%0d_rx", j), rx_cnt - c0, 1);
      chk($sformatf("lb%0d_word", j), rx_word, w);
      chk($sformatf("lb%0d_flag", j), rx_flag, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
